alu_op_bank: RTL and testbench



---
 rtl/alu_op_bank_if.sv | 24 ++
 rtl/alu_op_bank.sv | 93 +++++++++
 tb/tb_alu_op_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_bank_if.sv
// Signal bundle for alu_op_bank: operand capture handshake plus the twelve
// registered results and the two status flags.
interface alu_op_bank_if #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 7
);
    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic [RES_W-1:0]  c, d, e, f, g, h, i, j, k, l, m, n;
    logic              mul_ovf;
    logic              div_zero;

    modport master (
        output in_valid, a, b,
        input  out_valid, c, d, e, f, g, h, i, j, k, l, m, n, mul_ovf, div_zero
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, c, d, e, f, g, h, i, j, k, l, m, n, mul_ovf, div_zero
    );
endinterface

// File: rtl/alu_op_bank.sv
// Registered 4-bit two-operand ALU: twelve results in parallel, one-cycle latency.
// Define ALU_SAT_EN to saturate subtraction at 0 and multiplication at 127.
module alu_op_bank #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 7
) (
    input logic         clk,
    input logic         rst,
    alu_op_bank_if.slave bus
);

    localparam int WIDE_W = 2 * DATA_W;

    logic [WIDE_W-1:0] a_w, b_w, prod;
    logic [DATA_W-1:0] and_v, or_v, xor_v, nand_v, nor_v, nxor_v;
    logic [RES_W-1:0]  sum_r, diff_r, prod_r, quo_r, rem_r, shl_r;
    logic              ovf, dz;

    function automatic logic [RES_W-1:0] zext(input logic [DATA_W-1:0] x);
        return {{(RES_W-DATA_W){1'b0}}, x};
    endfunction

    always_comb begin
        a_w    = {{DATA_W{1'b0}}, bus.a};
        b_w    = {{DATA_W{1'b0}}, bus.b};
        prod   = a_w * b_w;
        ovf    = |prod[WIDE_W-1:RES_W];
        dz     = (bus.b == '0);
        sum_r  = RES_W'(a_w + b_w);
        shl_r  = RES_W'(a_w << bus.b[1:0]);
        // Division by zero reports all-ones quotient and passes a through as remainder.
        if (dz) begin
            quo_r = '1;
            rem_r = zext(bus.a);
        end else begin
            quo_r = RES_W'(a_w / b_w);
            rem_r = RES_W'(a_w % b_w);
        end
        // Inversions are kept at operand width so the upper result bits stay 0.
        and_v  = bus.a & bus.b;
        or_v   = bus.a | bus.b;
        xor_v  = bus.a ^ bus.b;
        nand_v = ~and_v;
        nor_v  = ~or_v;
        nxor_v = ~xor_v;
`ifdef ALU_SAT_EN
        diff_r = (bus.a < bus.b) ? '0 : RES_W'(a_w - b_w);
        prod_r = ovf ? '1 : prod[RES_W-1:0];
`else
        diff_r = RES_W'(a_w - b_w);
        prod_r = prod[RES_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.c         <= '0;
            bus.d         <= '0;
            bus.e         <= '0;
            bus.f         <= '0;
            bus.g         <= '0;
            bus.h         <= '0;
            bus.i         <= '0;
            bus.j         <= '0;
            bus.k         <= '0;
            bus.l         <= '0;
            bus.m         <= '0;
            bus.n         <= '0;
            bus.mul_ovf   <= 1'b0;
            bus.div_zero  <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.c        <= sum_r;
                bus.d        <= diff_r;
                bus.e        <= prod_r;
                bus.f        <= quo_r;
                bus.g        <= rem_r;
                bus.h        <= zext(and_v);
                bus.i        <= zext(or_v);
                bus.j        <= zext(xor_v);
                bus.k        <= zext(nand_v);
                bus.l        <= zext(nor_v);
                bus.m        <= zext(nxor_v);
                bus.n        <= shl_r;
                bus.mul_ovf  <= ovf;
                bus.div_zero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_bank.sv
// Scoreboard bench for alu_op_bank: expected result sets are queued when
// operands are driven and compared when out_valid reports them.
module tb_alu_op_bank;

    typedef struct {
        int c, d, e, f, g, h, i, j, k, l, m, n, mo, dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];
    res_t last;
    res_t zero;

    alu_op_bank_if bus ();

    alu_op_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input int a, input int b);
        res_t r;
        int   p;
        p = a * b;
        r.c = a + b;
`ifdef ALU_SAT_EN
        r.d = (a < b) ? 0 : a - b;
        r.e = (p > 127) ? 127 : p;
`else
        r.d = (a - b + 128) % 128;
        r.e = p % 128;
`endif
        r.mo = (p > 127) ? 1 : 0;
        if (b == 0) begin
            r.f = 127; r.g = a; r.dz = 1;
        end else begin
            r.f = a / b; r.g = a % b; r.dz = 0;
        end
        r.h = a & b;
        r.i = a | b;
        r.j = a ^ b;
        r.k = 15 - (a & b);
        r.l = 15 - (a | b);
        r.m = 15 - (a ^ b);
        r.n = a * (1 << (b % 4));
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.c = int'(bus.c); r.d = int'(bus.d); r.e = int'(bus.e); r.f = int'(bus.f);
        r.g = int'(bus.g); r.h = int'(bus.h); r.i = int'(bus.i); r.j = int'(bus.j);
        r.k = int'(bus.k); r.l = int'(bus.l); r.m = int'(bus.m); r.n = int'(bus.n);
        r.mo = int'(bus.mul_ovf); r.dz = int'(bus.div_zero);
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t o, input res_t x);
        check({tag, ".c"}, o.c, x.c);   check({tag, ".d"}, o.d, x.d);
        check({tag, ".e"}, o.e, x.e);   check({tag, ".f"}, o.f, x.f);
        check({tag, ".g"}, o.g, x.g);   check({tag, ".h"}, o.h, x.h);
        check({tag, ".i"}, o.i, x.i);   check({tag, ".j"}, o.j, x.j);
        check({tag, ".k"}, o.k, x.k);   check({tag, ".l"}, o.l, x.l);
        check({tag, ".m"}, o.m, x.m);   check({tag, ".n"}, o.n, x.n);
        check({tag, ".mul_ovf"}, o.mo, x.mo);
        check({tag, ".div_zero"}, o.dz, x.dz);
    endtask

    // One clock of stimulus; results are checked #1 after the capturing edge.
    task automatic cycle(input bit v, input int av, input int bv);
        @(negedge clk);
        bus.in_valid = v;
        bus.a = av[3:0];
        bus.b = bv[3:0];
        if (v) sb.push_back(model(av, bv));
        @(posedge clk);
        #1;
        check("out_valid", int'(bus.out_valid), int'(v));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                last = sb.pop_front();
                check_res("res", observe(), last);
            end
        end else begin
            check_res("hold", observe(), last);
        end
    endtask

    // rst pulse raised between edges and held across one edge.
    task automatic reset_pulse(input bit v, input int av, input int bv);
        @(negedge clk);
        bus.in_valid = v;
        bus.a = av[3:0];
        bus.b = bv[3:0];
        #2 rst = 1'b1;
        #1;
        check("rst_async.out_valid", int'(bus.out_valid), 0);
        check_res("rst_async", observe(), zero);
        @(posedge clk);
        #1;
        check("rst_held.out_valid", int'(bus.out_valid), 0);
        check_res("rst_held", observe(), zero);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        last = zero;
    endtask

    initial begin
        zero = '{default: 0};
        last = zero;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", int'(bus.out_valid), 0);
        check_res("reset", observe(), zero);
        @(negedge clk);
        rst = 1'b0;

        cycle(1, 6, 4);
        check("nom.c", int'(bus.c), 10);  check("nom.d", int'(bus.d), 2);
        check("nom.e", int'(bus.e), 24);  check("nom.f", int'(bus.f), 1);
        check("nom.g", int'(bus.g), 2);   check("nom.h", int'(bus.h), 4);
        check("nom.i", int'(bus.i), 6);   check("nom.j", int'(bus.j), 2);
        check("nom.k", int'(bus.k), 11);  check("nom.l", int'(bus.l), 9);
        check("nom.m", int'(bus.m), 13);  check("nom.n", int'(bus.n), 6);
        check("nom.mul_ovf", int'(bus.mul_ovf), 0);
        check("nom.div_zero", int'(bus.div_zero), 0);

        cycle(1, 9, 0);
        check("dz.f", int'(bus.f), 127);  check("dz.g", int'(bus.g), 9);
        check("dz.c", int'(bus.c), 9);    check("dz.n", int'(bus.n), 9);
        check("dz.div_zero", int'(bus.div_zero), 1);

        cycle(1, 15, 15);
`ifdef ALU_SAT_EN
        check("ovf.e", int'(bus.e), 127);
`else
        check("ovf.e", int'(bus.e), 97);
`endif
        check("ovf.mul_ovf", int'(bus.mul_ovf), 1);

        cycle(1, 4, 6);
`ifdef ALU_SAT_EN
        check("unf.d", int'(bus.d), 0);
`else
        check("unf.d", int'(bus.d), 126);
`endif
        check("unf.mul_ovf", int'(bus.mul_ovf), 0);

        cycle(1, 1, 2);   check("stream0.c", int'(bus.c), 3);
        cycle(1, 3, 3);   check("stream1.c", int'(bus.c), 6);
        cycle(1, 15, 1);  check("stream2.c", int'(bus.c), 16);
        cycle(0, 5, 5);   check("idle.c", int'(bus.c), 16);
        check("idle.out_valid", int'(bus.out_valid), 0);

        reset_pulse(0, 0, 0);
        cycle(1, 3, 5);
        reset_pulse(1, 7, 2);
        cycle(1, 7, 2);
        check("post_rst.c", int'(bus.c), 9);
        check("post_rst.n", int'(bus.n), 28);

        for (int t = 0; t < 80; t++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
        end
        cycle(0, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
